flog_issue_ctrl: RTL

Front-end issue controller for the bfloat16 log2 core (`top_top`). It accepts packed bfloat16 operands through a valid/ready stream and buffers them in a small FIFO. IEEE special cases are resolved locally without using the core. Normal operands are driven into the core's `sign/exponent/fractional/input_valid` port, the core result is collected, and one packed bfloat16 result is returned per operand, in order.

---
 rtl/flog_issue_ctrl_if.sv | 26 ++
 rtl/flog_issue_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/flog_issue_ctrl_if.sv
// flog_issue_ctrl_if
//   Operand/result stream bundle for the bfloat16 log2 issue controller.
//   master : the producer/consumer side (drives operands, accepts results)
//   slave  : the controller side (accepts operands, drives results)
//   in_data_i/in_valid_i/in_ready_o    : operand stream into the controller
//   out_data_o/out_valid_o/out_ready_i : result stream out of the controller
interface flog_issue_ctrl_if #(
  parameter int W = 16
) ();
  logic [W-1:0] in_data_i;
  logic         in_valid_i;
  logic         in_ready_o;
  logic [W-1:0] out_data_o;
  logic         out_valid_o;
  logic         out_ready_i;

  modport master (
    output in_data_i, in_valid_i, out_ready_i,
    input  in_ready_o, out_data_o, out_valid_o
  );

  modport slave (
    input  in_data_i, in_valid_i, out_ready_i,
    output in_ready_o, out_data_o, out_valid_o
  );
endinterface

// File: rtl/flog_issue_ctrl.sv
// flog_issue_ctrl
//   Front-end issue controller for the bfloat16 log2 core. Operands arrive on
//   a valid/ready stream into a small FIFO. IEEE special cases are answered
//   locally; normal operands are handed to the core one at a time and the
//   core result (or a quiet NaN on timeout) is returned in order.
// Ports:
//   clk, rst              : clock, asynchronous active-high reset
//   stream (slave)        : operand in / result out valid-ready streams
//   sign/exponent/fractional/input_valid : operand towards the core
//   s_res_i/e_res_i/f_res_i/valid_i      : result from the core
//   timeout_o             : one-cycle pulse when a core operation is aborted
module flog_issue_ctrl #(
  parameter int EXP        = 8,
  parameter int MAN        = 7,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic               clk,
  input  logic               rst,
  flog_issue_ctrl_if.slave   stream,
  output logic               sign,
  output logic [EXP-1:0]     exponent,
  output logic [MAN-1:0]     fractional,
  output logic               input_valid,
  input  logic               s_res_i,
  input  logic [EXP-1:0]     e_res_i,
  input  logic [MAN-1:0]     f_res_i,
  input  logic               valid_i,
  output logic               timeout_o
);
  localparam int W     = 1 + EXP + MAN;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  localparam logic [EXP-1:0]   EXP_ONES = {EXP{1'b1}};
  localparam logic [EXP-1:0]   EXP_ZERO = {EXP{1'b0}};
  localparam logic [MAN-1:0]   MAN_ZERO = {MAN{1'b0}};
  localparam logic [W-1:0]     RES_QNAN = {1'b0, EXP_ONES, 1'b1, {(MAN-1){1'b0}}};
  localparam logic [W-1:0]     RES_NINF = {1'b1, EXP_ONES, MAN_ZERO};
  localparam logic [W-1:0]     RES_PINF = {1'b0, EXP_ONES, MAN_ZERO};
  localparam logic [W-1:0]     RES_ZERO = {W{1'b0}};
  localparam logic [W-1:0]     VAL_ONE  = {2'b00, {(EXP-1){1'b1}}, MAN_ZERO};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [TMR_W-1:0] TMR_ZERO = {TMR_W{1'b0}};
  localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_RESULT = 2'd2
  } state_t;

  // Returns {is_special, local_result}; the first matching rule wins, so a
  // negative infinity is reported as NaN and -0 falls through to -inf.
  function automatic logic [W:0] classify_word(input logic [W-1:0] word);
    logic           w_sign;
    logic [EXP-1:0] w_exp;
    logic [MAN-1:0] w_man;
    logic [W:0]     res;
    w_sign = word[W-1];
    w_exp  = word[W-2 -: EXP];
    w_man  = word[MAN-1:0];
    if (w_exp == EXP_ONES && w_man != MAN_ZERO) begin
      res = {1'b1, RES_QNAN};
    end else if (w_sign && (w_exp != EXP_ZERO || w_man != MAN_ZERO)) begin
      res = {1'b1, RES_QNAN};
    end else if (w_exp == EXP_ZERO) begin
      res = {1'b1, RES_NINF};
    end else if (w_exp == EXP_ONES) begin
      res = {1'b1, RES_PINF};
    end else if (word == VAL_ONE) begin
      res = {1'b1, RES_ZERO};
    end else begin
      res = {1'b0, word};
    end
    return res;
  endfunction

  state_t           state_r, state_next;
  logic [W-1:0]     mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr_r, rd_ptr_next, wr_ptr_r;
  logic [CNT_W-1:0] count_r, count_next;
  logic [TMR_W-1:0] timer_r, timer_next;
  logic             sign_r, sign_next;
  logic [EXP-1:0]   exp_r, exp_next;
  logic [MAN-1:0]   man_r, man_next;
  logic             iv_r, iv_next;
  logic [W-1:0]     out_data_r, out_data_next;
  logic             out_valid_r, out_valid_next;
  logic             timeout_r, timeout_next;
  logic             push_s, pop_s;
  logic [W-1:0]     head_s;
  logic [W:0]       class_s;

  // Ready comes from the registered count only, so a pop frees space one cycle later.
  assign push_s  = stream.in_valid_i & (count_r != CNT_FULL);
  assign head_s  = mem_r[rd_ptr_r];
  assign class_s = classify_word(head_s);

  // FSM next state and next values of every registered output.
  always_comb begin
    state_next     = state_r;
    rd_ptr_next    = rd_ptr_r;
    timer_next     = timer_r;
    sign_next      = sign_r;
    exp_next       = exp_r;
    man_next       = man_r;
    iv_next        = iv_r;
    out_data_next  = out_data_r;
    out_valid_next = out_valid_r;
    timeout_next   = 1'b0;
    pop_s          = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (count_r != CNT_ZERO) begin
          pop_s       = 1'b1;
          rd_ptr_next = rd_ptr_r + PTR_ONE;
          if (class_s[W]) begin
            out_data_next  = class_s[W-1:0];
            out_valid_next = 1'b1;
            state_next     = ST_RESULT;
          end else begin
            sign_next  = head_s[W-1];
            exp_next   = head_s[W-2 -: EXP];
            man_next   = head_s[MAN-1:0];
            iv_next    = 1'b1;
            timer_next = TMR_ZERO;
            state_next = ST_ISSUE;
          end
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (valid_i) begin
          out_data_next  = {s_res_i, e_res_i, f_res_i};
          out_valid_next = 1'b1;
          iv_next        = 1'b0;
          state_next     = ST_RESULT;
        end else if (timer_r == TMR_LAST) begin
          // input_valid has now been high for exactly TIMEOUT cycles.
          out_data_next  = RES_QNAN;
          out_valid_next = 1'b1;
          timeout_next   = 1'b1;
          iv_next        = 1'b0;
          state_next     = ST_RESULT;
        end else begin
          timer_next = timer_r + TMR_ONE;
        end
      end
      ST_RESULT: begin
        if (stream.out_ready_i) begin
          out_valid_next = 1'b0;
          state_next     = ST_IDLE;
        end else begin
          state_next = ST_RESULT;
        end
      end
      default: begin
        iv_next        = 1'b0;
        out_valid_next = 1'b0;
        state_next     = ST_IDLE;
      end
    endcase
  end

  // FIFO occupancy update from the push/pop pair.
  always_comb begin
    count_next = count_r;
    case ({push_s, pop_s})
      2'b10:   count_next = count_r + CNT_ONE;
      2'b01:   count_next = count_r - CNT_ONE;
      default: count_next = count_r;
    endcase
  end

  // State, pointers and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      rd_ptr_r    <= PTR_ZERO;
      wr_ptr_r    <= PTR_ZERO;
      count_r     <= CNT_ZERO;
      timer_r     <= TMR_ZERO;
      sign_r      <= 1'b0;
      exp_r       <= EXP_ZERO;
      man_r       <= MAN_ZERO;
      iv_r        <= 1'b0;
      out_data_r  <= RES_ZERO;
      out_valid_r <= 1'b0;
      timeout_r   <= 1'b0;
    end else begin
      state_r     <= state_next;
      rd_ptr_r    <= rd_ptr_next;
      wr_ptr_r    <= push_s ? (wr_ptr_r + PTR_ONE) : wr_ptr_r;
      count_r     <= count_next;
      timer_r     <= timer_next;
      sign_r      <= sign_next;
      exp_r       <= exp_next;
      man_r       <= man_next;
      iv_r        <= iv_next;
      out_data_r  <= out_data_next;
      out_valid_r <= out_valid_next;
      timeout_r   <= timeout_next;
    end
  end

  // Operand storage; emptiness is tracked by count, so no reset is needed here.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= stream.in_data_i;
    end
  end

  assign stream.in_ready_o  = (count_r != CNT_FULL);
  assign stream.out_data_o  = out_data_r;
  assign stream.out_valid_o = out_valid_r;
  assign sign               = sign_r;
  assign exponent           = exp_r;
  assign fractional         = man_r;
  assign input_valid        = iv_r;
  assign timeout_o          = timeout_r;
endmodule
